hazard_ctrl: RTL
================

# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage RV32 core. It generates the stall, hold, bubble and flush controls for PC, IF/ID, ID/EX and EX/MEM. It covers three cases: load-use hazards, taken branches and jumps resolved in EX, and multi-cycle M-extension operations. For the M-extension case it sequences an external mul/div unit through a start/done handshake with a watchdog. It also keeps stall and flush performance counters.

## Interface
Parameters:
- MD_TIMEOUT, 64: maximum BUSY cycles before the watchdog aborts a mul/div operation (≥2).
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  one clock; reset is asynchronous and active-low.
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_uses_rs1  in  1  the ID instruction reads rs1.
- id_uses_rs2  in  1  the ID instruction reads rs2.
- id_ex_opcode  in  7  opcode in the ID/EX register.
- id_ex_funct7  in  7  funct7 in the ID/EX register.
- id_ex_rd  in  5  rd in the ID/EX register.
- branch_taken  in  1  the EX stage redirects the PC (branch, JAL or JALR).
- md_done  in  1  mul/div result valid; a single-cycle pulse.
- pc_stall  out  1  hold the PC.
- if_id_stall  out  1  hold the IF/ID register.
- if_id_flush  out  1  load a NOP into IF/ID.
- id_ex_bubble  out  1  load a NOP into ID/EX.
- id_ex_hold  out  1  hold the ID/EX register.
- ex_mem_bubble  out  1  load a NOP into EX/MEM (write enables 0).
- md_start  out  1  start pulse to the mul/div unit.
- md_busy  out  1  a mul/div operation is in flight (state START or BUSY).
- md_error  out  1  sticky watchdog-abort flag.
- stall_cycles  out  CNT_W  count of cycles with pc_stall=1.
- flush_count  out  CNT_W  count of cycles with if_id_flush=1.

## Operation
Decoded conditions:
- md_op: id_ex_opcode=0110011 and id_ex_funct7=0000001.
- load_use: id_ex_opcode=0000011, id_ex_rd≠0, and ((id_uses_rs1 and id_rs1=id_ex_rd) or (id_uses_rs2 and id_rs2=id_ex_rd)).

State machine: IDLE, START, BUSY, DONE. A 7-bit-or-wider watchdog counter runs in BUSY.

IDLE, with priority md_op > branch_taken > load_use:
- md_op: pc_stall, if_id_stall, id_ex_hold and ex_mem_bubble are 1; next state START.
- branch_taken: if_id_flush=1 and id_ex_bubble=1; pc_stall=0, so the PC loads the target.
- load_use: pc_stall=1, if_id_stall=1, id_ex_bubble=1. This is a single bubble; the condition clears when the load moves to MEM.
- Otherwise all controls are 0.

START:
- md_start=1, with the four md stalls held.
- Watchdog cleared to 0.
- md_done is ignored.
- Next state BUSY.

BUSY:
- md stalls held; watchdog increments each cycle.
- md_done=1: next state DONE.
- Watchdog reaches MD_TIMEOUT-1 with no md_done: md_error set to 1, next state DONE.

DONE:
- All controls 0, so EX/MEM captures the result and ID/EX advances.
- Next state IDLE.

Rules common to all states:
- branch_taken and load_use are ignored in START, BUSY and DONE.
- md_busy=1 in START and BUSY.
- md_error stays set until reset.
- stall_cycles increments on every cycle with pc_stall=1.
- flush_count increments on every cycle with if_id_flush=1.
- Both counters wrap modulo 2^CNT_W.

## Timing
- Reset, while rst_n=0:
  - State is IDLE.
  - All control outputs, including md_start, are forced to 0.
  - md_busy=0, md_error=0, stall_cycles=0, flush_count=0.
- Reset mid-operation: rst_n low in START or BUSY aborts immediately; no md_start is re-issued after release.
- Load-use and branch controls are combinational and take effect in the same cycle as the condition. Load-use costs 1 stall cycle; a taken branch costs 2 cycles (the IF/ID flush plus the ID/EX bubble).
- Mul/div sequence, with md_op first present in cycle 0:
  - Cycle 0 (IDLE): md stalls asserted.
  - Cycle 1 (START): md_start=1.
  - Cycles 2 onward (BUSY): md stalls held.
  - md_done sampled at cycle k: DONE at k+1 with controls released, IDLE at k+2.
  - Stall cycles total k+1.
- Back-to-back md ops: the second is detected in IDLE at k+2 and runs a fresh sequence.
- Watchdog: md_done absent, so DONE is entered MD_TIMEOUT+1 cycles after START and md_error rises on that same edge.
- Simultaneous md_done and watchdog expiry: treated as normal completion; md_error stays 0.
- md_done outside BUSY is ignored.

## Test plan
- Load-use: id_ex_opcode=0000011, id_ex_rd=5, id_rs2=5, id_uses_rs2=1 for 1 cycle -> pc_stall, if_id_stall and id_ex_bubble are 1 for exactly 1 cycle; stall_cycles=1. The same stimulus with id_ex_rd=0 -> no stall.
- Branch: branch_taken=1 together with a load_use condition -> if_id_flush=1, id_ex_bubble=1, pc_stall=0; flush_count increments by 1.
- Mul/div: md_op at cycle 0, md_done pulse at cycle 6 -> md_start only at cycle 1; md_busy=1 for cycles 1-6; stalls cycles 0-6; all controls 0 at cycle 7; stall_cycles=7.
- Watchdog, MD_TIMEOUT=8, md_done never asserted -> DONE entered 9 cycles after START; md_error=1 and stays 1. md_done pulsed later -> no effect.
- Async reset asserted mid-BUSY -> all outputs 0 immediately with no clock edge. After release with md_op still present -> a new sequence starts, with md_start one cycle after release.
- Counter wrap, CNT_W=4: 17 load-use stall cycles -> stall_cycles=1.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32 pipeline: load-use stalls,
// taken-branch flushes, and a start/done mul/div sequencer with watchdog and perf counters.
module hazard_ctrl #(
    parameter int MD_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [6:0]       id_ex_opcode,
    input  logic [6:0]       id_ex_funct7,
    input  logic [4:0]       id_ex_rd,
    input  logic             branch_taken,
    input  logic             md_done,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             id_ex_hold,
    output logic             ex_mem_bubble,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WD_W = ($clog2(MD_TIMEOUT) + 1 > 7) ? ($clog2(MD_TIMEOUT) + 1) : 7;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(MD_TIMEOUT - 1);

    localparam logic [6:0] OPC_OP   = 7'b0110011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

    state_t          state_reg, state_next;
    logic [WD_W-1:0] wd_reg, wd_next;
    logic            md_error_reg, md_error_next;

    logic md_op, load_use;
    logic pc_stall_c, if_id_stall_c, if_id_flush_c, id_ex_bubble_c;
    logic id_ex_hold_c, ex_mem_bubble_c, md_start_c;

    always_comb begin
        md_op    = (id_ex_opcode == OPC_OP) && (id_ex_funct7 == F7_MULDIV);
        load_use = (id_ex_opcode == OPC_LOAD) && (id_ex_rd != 5'd0) &&
                   ((id_uses_rs1 && (id_rs1 == id_ex_rd)) ||
                    (id_uses_rs2 && (id_rs2 == id_ex_rd)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wd_reg       <= '0;
            md_error_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wd_reg       <= wd_next;
            md_error_reg <= md_error_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        wd_next         = wd_reg;
        md_error_next   = md_error_reg;
        pc_stall_c      = 1'b0;
        if_id_stall_c   = 1'b0;
        if_id_flush_c   = 1'b0;
        id_ex_bubble_c  = 1'b0;
        id_ex_hold_c    = 1'b0;
        ex_mem_bubble_c = 1'b0;
        md_start_c      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (md_op) begin
                    pc_stall_c      = 1'b1;
                    if_id_stall_c   = 1'b1;
                    id_ex_hold_c    = 1'b1;
                    ex_mem_bubble_c = 1'b1;
                    state_next      = START;
                end else if (branch_taken) begin
                    // PC stays free so it loads the branch target this cycle
                    if_id_flush_c  = 1'b1;
                    id_ex_bubble_c = 1'b1;
                end else if (load_use) begin
                    pc_stall_c     = 1'b1;
                    if_id_stall_c  = 1'b1;
                    id_ex_bubble_c = 1'b1;
                end
            end
            START: begin
                pc_stall_c      = 1'b1;
                if_id_stall_c   = 1'b1;
                id_ex_hold_c    = 1'b1;
                ex_mem_bubble_c = 1'b1;
                md_start_c      = 1'b1;
                wd_next         = '0;
                state_next      = BUSY;
            end
            BUSY: begin
                pc_stall_c      = 1'b1;
                if_id_stall_c   = 1'b1;
                id_ex_hold_c    = 1'b1;
                ex_mem_bubble_c = 1'b1;
                wd_next         = wd_reg + 1'b1;
                // A done pulse on the expiry cycle still counts as normal completion
                if (md_done) begin
                    state_next = DONE;
                end else if (wd_reg == WD_LAST) begin
                    md_error_next = 1'b1;
                    state_next    = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Combinational controls are masked so nothing leaks out while reset is held
    assign pc_stall      = rst_n & pc_stall_c;
    assign if_id_stall   = rst_n & if_id_stall_c;
    assign if_id_flush   = rst_n & if_id_flush_c;
    assign id_ex_bubble  = rst_n & id_ex_bubble_c;
    assign id_ex_hold    = rst_n & id_ex_hold_c;
    assign ex_mem_bubble = rst_n & ex_mem_bubble_c;
    assign md_start      = rst_n & md_start_c;
    assign md_busy       = (state_reg == START) || (state_reg == BUSY);
    assign md_error      = md_error_reg;

    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_reg [2];

    assign cnt_inc = {if_id_flush, pc_stall};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_perf_cnt
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi]) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cycles = cnt_reg[0];
    assign flush_count  = cnt_reg[1];

endmodule
